// File: rtl/muldiv_pkg.sv
// Shared widths, op encodings and FSM states for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned Width = 16;
    localparam int unsigned Iters = 16;
    localparam int unsigned CntW  = $clog2(Iters);

    typedef enum logic [1:0] {
        OpMul  = 2'b00,
        OpMulh = 2'b01,
        OpDiv  = 2'b10,
        OpMod  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StFin  = 2'b10
    } state_e;

    function automatic logic is_div_op(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration: MSB-first shift-add multiply or restoring divide.
// The multiplier/dividend is consumed from shift_i[MSB]; quotient bits enter at the LSB.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned AccW = Width
) (
    input  logic             is_div_i,
    input  logic [Width-1:0] opnd_i,
    input  logic [Width-1:0] shift_i,
    input  logic [AccW-1:0]  acc_i,
    input  logic             ovf_i,
    output logic [Width-1:0] shift_o,
    output logic [AccW-1:0]  acc_o,
    output logic             ovf_o
);

    logic [Width-1:0] addend;
    logic [AccW:0]    sum;
    logic [Width:0]   rem_shift;
    logic [Width-1:0] rem_diff;
    logic             rem_ge;

    always_comb begin
        addend    = shift_i[Width-1] ? opnd_i : '0;
        sum       = {1'b0, acc_i[AccW-2:0], 1'b0} + (AccW+1)'(addend);
        rem_shift = {acc_i[Width-1:0], shift_i[Width-1]};
        rem_ge    = rem_shift >= {1'b0, opnd_i};
        // Only used when rem_ge, where the true difference always fits in Width bits.
        rem_diff  = rem_shift[Width-1:0] - opnd_i;

        if (is_div_i) begin
            shift_o = {shift_i[Width-2:0], rem_ge};
            acc_o   = AccW'(rem_ge ? rem_diff : rem_shift[Width-1:0]);
            ovf_o   = ovf_i;
        end else begin
            shift_o = {shift_i[Width-2:0], 1'b0};
            acc_o   = sum[AccW-1:0];
            // Sticky: once the running product leaves the accumulator it can only grow.
            ovf_o   = ovf_i | acc_i[AccW-1] | sum[AccW];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 16-bit multiply/divide unit, 16-clock latency, saturating MUL.
// Define MULDIV_MULH_EN to keep the full 32-bit product and support MULH.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] result_o,
    output logic             overflow_o,
    output logic             divzero_o
);

`ifdef MULDIV_MULH_EN
    localparam int unsigned AccW = 2 * Width;
`else
    localparam int unsigned AccW = Width;
`endif

    state_e           state_q;
    op_e              op_q;
    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] opnd_q, shift_q;
    logic [AccW-1:0]  acc_q;
    logic             ovf_q, dz_q;
    logic             busy_q, done_q, overflow_q, divzero_q;
    logic [Width-1:0] result_q;

    logic [Width-1:0] step_shift;
    logic [AccW-1:0]  step_acc;
    logic             step_ovf;
    logic             mul_ovf, fin_ovf, req_div, req_dz;
    logic [Width-1:0] fin_result;

    muldiv_step #(
        .AccW(AccW)
    ) u_step (
        .is_div_i(is_div_op(op_q)),
        .opnd_i  (opnd_q),
        .shift_i (shift_q),
        .acc_i   (acc_q),
        .ovf_i   (ovf_q),
        .shift_o (step_shift),
        .acc_o   (step_acc),
        .ovf_o   (step_ovf)
    );

    always_comb begin
        req_div = is_div_op(op_e'(op_i));
        req_dz  = req_div && (b_i == '0);
`ifdef MULDIV_MULH_EN
        mul_ovf = step_ovf | (|step_acc[AccW-1:Width]);
`else
        mul_ovf = step_ovf;
`endif
        fin_result = '0;
        fin_ovf    = 1'b0;
        if (dz_q) begin
            // Divide-by-zero skipped iteration, so shift_q still holds the dividend.
            fin_result = (op_q == OpDiv) ? '1 : shift_q;
        end else begin
            unique case (op_q)
                OpMul: begin
                    fin_ovf    = mul_ovf;
                    fin_result = mul_ovf ? '1 : step_acc[Width-1:0];
                end
`ifdef MULDIV_MULH_EN
                OpMulh: fin_result = step_acc[AccW-1:Width];
`else
                OpMulh: fin_result = '0;
`endif
                OpDiv:  fin_result = step_shift;
                OpMod:  fin_result = step_acc[Width-1:0];
                default: fin_result = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= OpMul;
            cnt_q      <= '0;
            opnd_q     <= '0;
            shift_q    <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            divzero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StFin: begin
                    if (start_i) begin
                        op_q    <= op_e'(op_i);
                        opnd_q  <= req_div ? b_i : a_i;
                        shift_q <= req_div ? a_i : b_i;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        dz_q    <= req_dz;
                        // Divide-by-zero finishes on the very next edge.
                        cnt_q   <= req_dz ? CntW'(Iters - 1) : '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    shift_q <= step_shift;
                    acc_q   <= step_acc;
                    ovf_q   <= step_ovf;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(Iters - 1)) begin
                        state_q    <= StFin;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        result_q   <= fin_result;
                        overflow_q <= fin_ovf;
                        divzero_q  <= dz_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign overflow_o = overflow_q;
    assign divzero_o  = divzero_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, asynchronous assert, active-low (0 = reset), released synchronously to clk.
REQ-003 SHALL: start  input  1  request pulse; sampled only when busy=0.
REQ-004 SHALL: op  input  2  00 MUL (low 16 bits), 01 MULH (high 16 bits), 10 DIV (quotient), 11 MOD (remainder).
REQ-005 SHALL: a  input  16  unsigned multiplicand or dividend; b  input  16  unsigned multiplier or divisor.
REQ-006 SHALL: busy  output  1  operation in progress; start ignored while high.
REQ-007 SHALL: done  output  1  single-cycle pulse; result, overflow and divzero valid.
REQ-008 SHALL: result  output  16  held from done until the next accepted start completes; feeds the ALU muldiv input.
REQ-009 SHALL: overflow  output  1  MUL product exceeded 16 bits; divzero  output  1  DIV/MOD with b=0.

Function
REQ-010 SHALL: FSM states IDLE, RUN, FIN; IDLE/FIN + start -> RUN (or FIN on divide-by-zero); RUN + count=15 -> FIN; FIN without start -> IDLE.
REQ-011 SHALL: start accepted at edge N latches op, a, b, clears 4-bit counter; busy=1 after N through N+15.
REQ-012 SHALL: MUL/MULH shift-add, one multiplier bit per cycle, 32-bit product; DIV/MOD restoring, one quotient bit per cycle.
REQ-013 SHALL: at edge N+16 state=FIN, busy=0, done=1, result/flags updated; latency exactly 16 clocks for all ops.
REQ-014 SHALL: MUL with product[31:16]!=0 -> result=16'hFFFF (saturate), overflow=1; otherwise overflow=0.
REQ-015 SHALL: MULH -> result=product[31:16], overflow=0.
REQ-016 SHALL: DIV/MOD with b=0 -> skip RUN, FIN at edge N+1, divzero=1, DIV result=16'hFFFF, MOD result=a.
REQ-017 SHALL: divzero=0 and overflow=0 for every op not meeting REQ-014/REQ-016.
REQ-018 SHALL: start while busy=1 has no effect; start during FIN (done=1) is accepted, back-to-back.
REQ-019 SHALL: done deasserts after one cycle; result, overflow, divzero hold until next FIN.

Reset
REQ-020 SHALL: rst=0 at any time, including mid-RUN, aborts the operation: state=IDLE, busy=0, done=0, result=0, overflow=0, divzero=0, counter=0.
REQ-021 SHALL: no done pulse follows an aborted operation.

Configuration
REQ-022 SHALL: macro MULDIV_MULH_EN defined -> full 32-bit product kept, op 01 per REQ-015.
REQ-023 SHALL: MULDIV_MULH_EN undefined -> op 01 completes with normal latency, result=0, overflow=0; upper-product storage beyond overflow detect removed.

Structure
REQ-024 SHALL: package muldiv_pkg holds data width (16), iteration count (16), op encodings, FSM state encodings.
REQ-025 SHALL: combinational sub-module muldiv_step performs one shift-add or restoring-subtract iteration; muldiv_unit owns FSM, counter, operand/result registers.

Verification
REQ-026 SHALL: MUL a=300 b=200 -> done at N+16, result=16'hEA60, overflow=0.
REQ-027 SHALL: MUL a=16'h1234 b=16'h0100 -> result=16'hFFFF, overflow=1; MULH same operands -> result=16'h0012 (macro on) / 16'h0000 (macro off).
REQ-028 SHALL: DIV a=1000 b=7 -> result=142; MOD same -> result=6; divzero=0.
REQ-029 SHALL: DIV a=50 b=0 -> done at N+1, result=16'hFFFF, divzero=1; MOD a=50 b=0 -> result=50.
REQ-030 SHALL: start pulse at N+5 during MUL ignored; rst=0 at N+8 -> all outputs 0, no done; new MUL after release completes correctly.
REQ-031 SHALL: start asserted in done cycle -> second op accepted, done again exactly 16 clocks later.
